combo_lock_param: RTL



---
 rtl/combo_lock_param.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/combo_lock_param.sv
// Parametrised serial-bit combination lock with programmable code,
// consecutive-failure counting and a timed lockout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// LOCKED    | collecting an attempt, one bit per X_VALID strobe
// UNLOCKED  | correct code seen; waiting for RELOCK or PROG
// PROGRAM   | collecting a new code; old code stays active until done
// LOCKOUT   | too many failures; all inputs ignored until timer expires
module combo_lock_param #(
    parameter int                  CODE_LEN       = 7,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 7'b0110111,
    parameter int                  MAX_FAILS      = 3,
    parameter int                  LOCKOUT_CYCLES = 16,
    localparam int                 PW             = $clog2(CODE_LEN + 1)
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          X,
    input  logic          X_VALID,
    input  logic          RELOCK,
    input  logic          PROG,
    output logic          UNLK,
    output logic          HINT,
    output logic          LOCKOUT,
    output logic          PROG_ACT,
    output logic [3:0]    FAILS,
    output logic [PW-1:0] POS
);

    localparam int CW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [1:0] ST_LOCKED   = 2'd0;
    localparam logic [1:0] ST_UNLOCKED = 2'd1;
    localparam logic [1:0] ST_PROGRAM  = 2'd2;
    localparam logic [1:0] ST_LOCKOUT  = 2'd3;

    localparam logic [3:0]    FAILS_MAX = 4'(MAX_FAILS);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(LOCKOUT_CYCLES - 1);
    localparam logic [PW-1:0] LAST_POS  = PW'(CODE_LEN - 1);

    logic [1:0]          state, state_nxt;
    logic [CODE_LEN-1:0] code_reg, code_nxt;
    logic [CODE_LEN-2:0] shift_reg, shift_nxt;
    logic [PW-1:0]       pos_nxt;
    logic [3:0]          fails_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;

    // Attempt and staging share one shift register; "taken" is the word
    // including the bit on X, so the final bit can be compared in-edge.
    logic [CODE_LEN-1:0] taken;
    logic [CODE_LEN-1:0] code_sh;
    logic                last_bit;

    assign taken    = {shift_reg, X};
    assign code_sh  = code_reg << POS;
    assign last_bit = (POS == LAST_POS);

    // Per-bit hint against the currently active code (old code in PROGRAM).
    assign HINT = ((state == ST_LOCKED) || (state == ST_PROGRAM)) &&
                  (X == code_sh[CODE_LEN-1]);

    // Next-state and datapath decisions for all four states.
    always_comb begin
        state_nxt = state;
        code_nxt  = code_reg;
        shift_nxt = shift_reg;
        pos_nxt   = POS;
        fails_nxt = FAILS;
        cnt_nxt   = cnt;
        case (state)
            ST_LOCKED: begin
                if (X_VALID) begin
                    if (last_bit) begin
                        pos_nxt   = '0;
                        shift_nxt = '0;
                        if (taken == code_reg) begin
                            state_nxt = ST_UNLOCKED;
                            fails_nxt = '0;
                        end else if (FAILS + 4'd1 >= FAILS_MAX) begin
                            state_nxt = ST_LOCKOUT;
                            fails_nxt = FAILS_MAX;
                            cnt_nxt   = CNT_LOAD;
                        end else begin
                            fails_nxt = FAILS + 4'd1;
                        end
                    end else begin
                        pos_nxt   = POS + PW'(1);
                        shift_nxt = taken[CODE_LEN-2:0];
                    end
                end
            end
            ST_UNLOCKED: begin
                if (RELOCK) begin
                    state_nxt = ST_LOCKED;
                end else if (PROG) begin
                    state_nxt = ST_PROGRAM;
                    pos_nxt   = '0;
                    shift_nxt = '0;
                end
            end
            ST_PROGRAM: begin
                if (RELOCK) begin
                    state_nxt = ST_LOCKED;
                    pos_nxt   = '0;
                    shift_nxt = '0;
                end else if (X_VALID) begin
                    if (last_bit) begin
                        code_nxt  = taken;
                        pos_nxt   = '0;
                        shift_nxt = '0;
                        state_nxt = ST_LOCKED;
                    end else begin
                        pos_nxt   = POS + PW'(1);
                        shift_nxt = taken[CODE_LEN-2:0];
                    end
                end
            end
            default: begin
                if (cnt == '0) begin
                    state_nxt = ST_LOCKED;
                    fails_nxt = '0;
                    pos_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
        endcase
    end

    // State, datapath and registered status flags.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state     <= ST_LOCKED;
            code_reg  <= DEFAULT_CODE;
            shift_reg <= '0;
            POS       <= '0;
            FAILS     <= '0;
            cnt       <= '0;
            UNLK      <= 1'b0;
            LOCKOUT   <= 1'b0;
            PROG_ACT  <= 1'b0;
        end else begin
            state     <= state_nxt;
            code_reg  <= code_nxt;
            shift_reg <= shift_nxt;
            POS       <= pos_nxt;
            FAILS     <= fails_nxt;
            cnt       <= cnt_nxt;
            UNLK      <= (state_nxt == ST_UNLOCKED);
            LOCKOUT   <= (state_nxt == ST_LOCKOUT);
            PROG_ACT  <= (state_nxt == ST_PROGRAM);
        end
    end

endmodule
